// File: rtl/retire_stage.sv
// In-order commit stage: retires the longest completed prefix of the ROB exit
// packets, frees T_old registers, updates the architectural map and tracks halt.
`ifndef N
`define N 2
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

module retire_stage #(
  parameter int N           = `N,
  parameter int PHYS_REG_SZ = `PHYS_REG_SZ,
  parameter int ARCH_REG_SZ = 32,
  localparam int PR_W            = $clog2(PHYS_REG_SZ),
  localparam int AR_W            = $clog2(ARCH_REG_SZ),
  localparam int PKT_W           = 2 * PR_W + AR_W + 2,
  localparam int NUM_SCALAR_BITS = $clog2(N + 1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N-1:0][PKT_W-1:0]             rob_outputs,
  input  logic [NUM_SCALAR_BITS-1:0]          outputs_valid,
  input  logic [PHYS_REG_SZ-1:0]              complete_list,
  output logic [NUM_SCALAR_BITS-1:0]          num_retiring,
  output logic [N-1:0][PR_W-1:0]              freed_regs,
  output logic [N-1:0]                        freed_valid,
  output logic [ARCH_REG_SZ-1:0][PR_W-1:0]    arch_map,
  output logic                                halted,
  output logic [63:0]                         retired_count
);

  localparam logic RUN    = 1'b0;
  localparam logic HALTED = 1'b1;

  // Packet layout, MSB to LSB: T_new, T_old, Arch_reg, has_dest, halt.
  typedef struct packed {
    logic [PR_W-1:0] t_new;
    logic [PR_W-1:0] t_old;
    logic [AR_W-1:0] arch_reg;
    logic            has_dest;
    logic            halt;
  } pkt_t;

  pkt_t [N-1:0] pkt;
  assign pkt = rob_outputs;

  logic                             state_q, state_d;
  logic [ARCH_REG_SZ-1:0][PR_W-1:0] arch_map_q, arch_map_d;
  logic [63:0]                      retired_count_q, retired_count_d;
  logic [N-1:0]                     retires;
  logic                             blocked;
  logic                             ready;
  logic                             halt_retiring;

  // Retirement stops at the first non-ready entry or right after a halt.
  always_comb begin
    retires       = '0;
    num_retiring  = '0;
    halt_retiring = 1'b0;
    ready         = 1'b0;
    blocked       = (state_q != RUN) || !reset;
    for (int i = 0; i < N; i++) begin
      freed_regs[i] = pkt[i].t_old;
      ready = (i < int'(outputs_valid)) &&
              (!pkt[i].has_dest || complete_list[pkt[i].t_new]);
      if (!blocked && ready) begin
        retires[i]   = 1'b1;
        num_retiring = num_retiring + NUM_SCALAR_BITS'(1);
        if (pkt[i].halt) begin
          halt_retiring = 1'b1;
          blocked       = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
      freed_valid[i] = retires[i] && pkt[i].has_dest;
    end
  end

  // Younger entries overwrite older ones; x0 stays hardwired to physical 0.
  always_comb begin
    arch_map_d      = arch_map_q;
    retired_count_d = retired_count_q + 64'(num_retiring);
    state_d         = state_q;
    for (int i = 0; i < N; i++) begin
      if (freed_valid[i] && (pkt[i].arch_reg != '0))
        arch_map_d[pkt[i].arch_reg] = pkt[i].t_new;
    end
    if (state_q == RUN && halt_retiring)
      state_d = HALTED;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= RUN;
      retired_count_q <= '0;
      for (int r = 0; r < ARCH_REG_SZ; r++)
        arch_map_q[r] <= PR_W'(r);
    end else begin
      state_q         <= state_d;
      retired_count_q <= retired_count_d;
      arch_map_q      <= arch_map_d;
    end
  end

  assign arch_map      = arch_map_q;
  assign halted        = (state_q == HALTED);
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_retire_stage.sv
// Self-checking bench for retire_stage: directed vector table followed by
// randomized traffic, both compared against a prefix-scan reference model.
`ifndef N
`define N 2
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

module tb_retire_stage;
  localparam int N     = 2;
  localparam int PHYS  = 64;
  localparam int ARCH  = 32;
  localparam int PR_W  = $clog2(PHYS);
  localparam int AR_W  = $clog2(ARCH);
  localparam int PKT_W = 2 * PR_W + AR_W + 2;
  localparam int NSB   = $clog2(N + 1);

  logic                          clock = 1'b0;
  logic                          reset;
  logic [N-1:0][PKT_W-1:0]       rob_outputs;
  logic [NSB-1:0]                outputs_valid;
  logic [PHYS-1:0]               complete_list;
  logic [NSB-1:0]                num_retiring;
  logic [N-1:0][PR_W-1:0]        freed_regs;
  logic [N-1:0]                  freed_valid;
  logic [ARCH-1:0][PR_W-1:0]     arch_map;
  logic                          halted;
  logic [63:0]                   retired_count;

  retire_stage #(.N(N), .PHYS_REG_SZ(PHYS), .ARCH_REG_SZ(ARCH)) dut (
    .clock(clock), .reset(reset), .rob_outputs(rob_outputs),
    .outputs_valid(outputs_valid), .complete_list(complete_list),
    .num_retiring(num_retiring), .freed_regs(freed_regs),
    .freed_valid(freed_valid), .arch_map(arch_map), .halted(halted),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Architectural state as the model sees it
  logic [ARCH-1:0][PR_W-1:0] m_map;
  bit                        m_halted;
  longint unsigned           m_count;

  typedef struct {
    logic [PKT_W-1:0] e0;
    logic [PKT_W-1:0] e1;
    logic [1:0]       valid;
    logic [PHYS-1:0]  cl;
    logic             rst;
    int               exp_num;
    logic [1:0]       exp_fv;
  } vec_t;

  function automatic logic [PKT_W-1:0] mk(int arch, int tn, int to, bit hd, bit h);
    return {PR_W'(tn), PR_W'(to), AR_W'(arch), hd, h};
  endfunction

  function automatic logic [PHYS-1:0] bits2(int a, int b);
    logic [PHYS-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < ARCH; r++) m_map[r] = PR_W'(r);
    m_halted = 0;
    m_count  = 0;
  endtask

  // Expected retirement length: longest completed prefix, cut after a halt.
  task automatic checkOutput(output int k, output logic [N-1:0] efv, output bit hit_halt);
    logic [PKT_W-1:0] p;
    int tn;
    bit hd;
    k = 0; efv = '0; hit_halt = 0;
    if (reset && !m_halted) begin
      while (k < int'(outputs_valid)) begin
        p  = rob_outputs[k];
        tn = int'(p[PKT_W-1 -: PR_W]);
        hd = p[1];
        if (hd && !complete_list[tn]) break;
        efv[k] = hd;
        k++;
        if (p[0]) begin hit_halt = 1; break; end
      end
    end
    chk("num_retiring", 64'(num_retiring), 64'(k));
    chk("freed_valid", 64'(freed_valid), 64'(efv));
    for (int i = 0; i < N; i++) begin
      p = rob_outputs[i];
      chk($sformatf("freed_regs[%0d]", i), 64'(freed_regs[i]), 64'(p[PKT_W-PR_W-1 -: PR_W]));
    end
    chk("halted", 64'(halted), 64'(m_halted));
    chk("retired_count", retired_count, m_count);
    checks++;
    if (arch_map !== m_map) begin
      errors++;
      $display("[TB] FAIL arch_map: got %h expected %h", arch_map, m_map);
    end
  endtask

  task automatic modelCommit(input int k, input bit hit_halt);
    logic [PKT_W-1:0] p;
    int arch;
    if (!reset) begin
      modelReset();
      return;
    end
    for (int i = 0; i < k; i++) begin
      p    = rob_outputs[i];
      arch = int'(p[AR_W+1:2]);
      if (p[1] && arch != 0) m_map[arch] = p[PKT_W-1 -: PR_W];
    end
    m_count += longint'(k);
    if (hit_halt) m_halted = 1;
  endtask

  // Drive one cycle of inputs at the negedge, check, then advance the model.
  task automatic applyStimulus(input logic [PKT_W-1:0] e0, input logic [PKT_W-1:0] e1,
                               input logic [1:0] v, input logic [PHYS-1:0] cl,
                               input logic rst, output int k, output logic [N-1:0] efv);
    bit hh;
    @(negedge clock);
    rob_outputs[0] = e0;
    rob_outputs[1] = e1;
    outputs_valid  = NSB'(v);
    complete_list  = cl;
    reset          = rst;
    #1;
    checkOutput(k, efv, hh);
    modelCommit(k, hh);
  endtask

  vec_t vecs[$];

  initial begin
    int k;
    logic [N-1:0] efv;
    logic [PKT_W-1:0] e0, e1;
    reset         = 1'b0;
    rob_outputs   = '0;
    outputs_valid = '0;
    complete_list = '0;
    modelReset();

    vecs.push_back('{mk(1,1,1,1,0), mk(2,2,2,1,0), 2, '1, 0, 0, 2'b00});
    vecs.push_back('{mk(1,1,1,1,0), mk(2,2,2,1,0), 2, '1, 0, 0, 2'b00});
    vecs.push_back('{mk(3,40,3,1,0), mk(4,41,4,1,0), 2, bits2(40,41), 1, 2, 2'b11});
    vecs.push_back('{mk(3,40,3,1,0), mk(4,41,4,1,0), 2, bits2(-1,41), 1, 0, 2'b00});
    vecs.push_back('{mk(3,40,3,1,0), mk(4,41,4,1,0), 2, bits2(40,41), 1, 2, 2'b11});
    vecs.push_back('{mk(7,50,10,1,0), mk(7,51,11,1,0), 2, bits2(50,51), 1, 2, 2'b11});
    vecs.push_back('{mk(5,45,15,1,0), mk(6,46,16,1,0), 0, '1, 1, 0, 2'b00});
    vecs.push_back('{mk(5,45,15,1,0), mk(6,46,16,1,0), 1, bits2(45,46), 1, 1, 2'b01});
    vecs.push_back('{mk(9,30,13,0,0), mk(10,53,14,1,0), 2, bits2(53,-1), 1, 2, 2'b10});
    vecs.push_back('{mk(8,52,12,1,1), mk(11,54,17,1,0), 2, bits2(52,54), 1, 1, 2'b01});
    vecs.push_back('{mk(12,55,18,1,0), mk(13,56,19,1,0), 2, bits2(55,56), 1, 0, 2'b00});
    vecs.push_back('{mk(12,55,18,1,0), mk(13,56,19,1,0), 2, bits2(55,56), 1, 0, 2'b00});
    vecs.push_back('{mk(12,55,18,1,0), mk(13,56,19,1,0), 2, bits2(55,56), 0, 0, 2'b00});
    vecs.push_back('{mk(0,60,20,1,0), mk(0,61,21,0,0), 2, bits2(60,-1), 1, 2, 2'b01});
    vecs.push_back('{mk(0,0,0,0,0), mk(0,0,0,0,0), 0, '0, 1, 0, 2'b00});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].e0, vecs[i].e1, vecs[i].valid, vecs[i].cl, vecs[i].rst, k, efv);
      chk($sformatf("vec%0d num", i), 64'(num_retiring), 64'(vecs[i].exp_num));
      chk($sformatf("vec%0d fv", i), 64'(freed_valid), 64'(vecs[i].exp_fv));
      if (i == 3) begin
        chk("map3 after full retire", 64'(arch_map[3]), 64'd40);
        chk("map4 after full retire", 64'(arch_map[4]), 64'd41);
        chk("count after full retire", retired_count, 64'd2);
      end
    end
    chk("x0 stays zero", 64'(arch_map[0]), 64'd0);
    chk("count after halt reset", retired_count, 64'd2);
    chk("map5 reset value", 64'(arch_map[5]), 64'd5);

    // Reset discards the retirement that is in flight that cycle
    applyStimulus(mk(14,33,22,1,0), mk(15,34,23,1,0), 2, bits2(33,34), 0, k, efv);
    applyStimulus(mk(0,0,0,0,0), mk(0,0,0,0,0), 0, '0, 1, k, efv);
    chk("map14 after reset discard", 64'(arch_map[14]), 64'd14);
    chk("count after reset discard", retired_count, 64'd0);

    for (int n = 0; n < 400; n++) begin
      e0 = mk($urandom_range(0, 7), $urandom_range(0, PHYS-1), $urandom_range(0, PHYS-1),
              $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
      e1 = mk($urandom_range(0, 7), $urandom_range(0, PHYS-1), $urandom_range(0, PHYS-1),
              $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
      applyStimulus(e0, e1, 2'($urandom_range(0, 2)),
                    {$urandom, $urandom} | {$urandom, $urandom},
                    $urandom_range(0, 24) != 0, k, efv);
    end
    applyStimulus(mk(0,0,0,0,0), mk(0,0,0,0,0), 0, '0, 1, k, efv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_stage.md
# retire_stage

In-order commit stage on the consuming end of the ROB exit port. Each cycle it inspects the oldest `outputs_valid` ROB exit packets, retires the longest completed prefix, and returns `num_retiring` to the ROB. It frees each retiring instruction's T_old to the free list and updates the architectural map table. A halt-tracking FSM and a retired-instruction counter are included for testbench termination and CPI reporting.

## Interface
- Parameters:
- N, `N, superscalar width; max retirements per cycle
- PHYS_REG_SZ, `PHYS_REG_SZ, physical register count; T_new/T_old width is $clog2(PHYS_REG_SZ)
- ARCH_REG_SZ, 32, architectural register count; Arch_reg width is $clog2(ARCH_REG_SZ)
- NUM_SCALAR_BITS (localparam), $clog2(N+1)
- Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-low; reset==0 at a posedge resets all state
- rob_outputs  in  ROB_EXIT_PACKET[N-1:0]  oldest at index 0; fields used: T_new, T_old, Arch_reg, has_dest, halt
- outputs_valid  in  NUM_SCALAR_BITS  count of valid entries; entries at index ≥ outputs_valid are ignored
- complete_list  in  PHYS_REG_SZ  bit p=1 means physical reg p has been written back
- num_retiring  out  NUM_SCALAR_BITS  entries the ROB clears this cycle (combinational)
- freed_regs  out  [N-1:0][$clog2(PHYS_REG_SZ)-1:0]  T_old of retiring entries, in age order
- freed_valid  out  N  bit i valid for freed_regs[i] (combinational)
- arch_map  out  [ARCH_REG_SZ-1:0][$clog2(PHYS_REG_SZ)-1:0]  architectural map table (registered)
- halted  out  1  registered; 1 once a halt has retired
- retired_count  out  64  registered; total instructions retired since reset

## Operation
- Entry i is *ready* iff i < outputs_valid and complete_list[rob_outputs[i].T_new]==1. A non-dest entry (has_dest==0) is ready whenever i < outputs_valid.
- Entry i *retires* iff state==RUN, entry i is ready, every entry j<i retires, and no entry j<i has halt==1.
- num_retiring = count of retiring entries. This count is always a contiguous prefix, so num_retiring ≤ outputs_valid ≤ N.
- A halt entry retires itself and blocks all younger entries in the same cycle.
- freed_valid[i] = retires[i] && has_dest[i]; freed_regs[i] = rob_outputs[i].T_old, driven for all i regardless of valid.
- Map update at posedge: for i = 0..N-1 in order, if retires[i] && has_dest[i], set arch_map[Arch_reg[i]] <= T_new[i]. On duplicate Arch_reg, the younger (higher i) entry wins. Arch_reg==0 is never written; arch_map[0] stays 0.
- retired_count <= retired_count + num_retiring, as a 64-bit wrap-free increment.
- FSM:
  - RUN: if any retiring entry has halt==1, go to HALTED.
  - HALTED: num_retiring=0, freed_valid=0, no map or count updates; stays in HALTED until reset.

## Timing
- num_retiring, freed_regs, and freed_valid are combinational from rob_outputs, outputs_valid, complete_list, and state, with zero-cycle latency. The ROB samples num_retiring at the same posedge.
- arch_map, halted, and retired_count reflect a retirement one cycle after the cycle in which it is reported.
- Reset values (reset==0 at a posedge):
  - state=RUN, halted=0, retired_count=0
  - arch_map[r]=r for all r
  - Combinational outputs follow from these values in the following cycle. While reset is low, num_retiring=0 and freed_valid=0.
- Reset mid-operation, including while HALTED, returns to RUN and discards any in-flight retirement of that cycle.
- outputs_valid=0 gives num_retiring=0 with no state change.
- An incomplete entry at index 0 gives num_retiring=0 even if younger entries are complete.
- complete_list is sampled only in the current cycle. No internal history is kept; the ROB re-presents unretired entries.

## Test plan
- Reset: hold reset=0 two cycles -> num_retiring=0, halted=0, retired_count=0, arch_map[5]=5.
- Full retire: N=2, outputs_valid=2, entries {Arch 3, T_new 40, T_old 3}, {Arch 4, T_new 41, T_old 4}, complete_list[40]=[41]=1 -> same cycle num_retiring=2, freed_valid=2'b11, freed_regs={4,3}; next cycle arch_map[3]=40, arch_map[4]=41, retired_count=2.
- Prefix gap: same entries but complete_list[40]=0, [41]=1 -> num_retiring=0, freed_valid=0. Then set [40]=1 -> num_retiring=2.
- Duplicate dest: both entries Arch 7, T_new 50 then 51, both complete -> arch_map[7]=51, freed_regs={T_old1, T_old0}, both valid.
- Halt: entry0 halt=1 complete, entry1 complete -> num_retiring=1, next cycle halted=1. Subsequent cycles with valid complete entries -> num_retiring=0, retired_count frozen.
- Reset while HALTED plus x0 write: reset=0 one cycle -> halted=0. Then retire Arch_reg=0 with T_new 60 -> arch_map[0]=0, freed_valid set only if has_dest=1.
